serial_block_loader: RTL and testbench
======================================

# serial_block_loader

Serial-to-parallel input stage of the AES-128 datapath. Collects a 1-bit serial plaintext stream qualified by `data_valid_in` into 128-bit blocks and presents each completed block, with a valid/ready handshake, to the Subbytes round stage. Holds one completed block while the next is being shifted in, and flags blocks lost to backpressure.

## Interface
- `TIMEOUT_CYC`, 16: idle-gap length (cycles) that aborts a partial block; used only when `SBL_TIMEOUT_EN` is defined; legal range 1..255.
- `clk`  input  1  system clock, all state on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_valid_in`  input  1  `data_in` carries a valid bit this cycle.
- `data_in`  input  1  serial plaintext bit, MSB of block first.
- `ready_in`  input  1  downstream accepts `block_out` this cycle; tie high for Subbytes.
- `block_out`  output  128  completed plaintext block.
- `valid_out`  output  1  `block_out` holds an unconsumed block.
- `bit_cnt`  output  7  bits collected in current partial block (0..127).
- `overrun`  output  1  one-cycle pulse: completed block dropped.
- `abort`  output  1  one-cycle pulse: partial block discarded by timeout.

## Operation
- Shift register `sr[127:0]`: on each cycle with `data_valid_in`=1, `sr <= {sr[126:0], data_in}`, `bit_cnt` increments. First bit received ends up in `block_out[127]`.
- Collector states: IDLE (`bit_cnt`=0, no bits yet), LOAD (1..127 bits held). IDLE->LOAD on first valid bit; LOAD->IDLE when the 128th valid bit is sampled (completion) or on abort. `bit_cnt` wraps 127->0 on completion.
- Output register: states EMPTY (`valid_out`=0), FULL (`valid_out`=1).
  - Consume: FULL and `ready_in`=1 -> EMPTY, unless a completion occurs that same edge.
  - Completion while EMPTY, or while FULL with `ready_in`=1: `block_out` <= `{sr[126:0], data_in}`, state FULL.
  - Completion while FULL with `ready_in`=0: new block discarded, `block_out` unchanged, `overrun`=1 for one cycle; collector still restarts at 0.
- `block_out` changes only on a load; it is stable whenever `valid_out`=1 and not consumed.
- `data_valid_in`=0 cycles are ignored (no shift, no count change) except for timeout counting.

## Timing
- Reset (asynchronous assert, any cycle including mid-block): `sr`=0, `bit_cnt`=0, `block_out`=0, `valid_out`=0, `overrun`=0, `abort`=0, timeout counter 0. Partial and held blocks are lost.
- Latency: `valid_out`=1 and `block_out` valid immediately after the rising edge that samples the 128th bit.
- Minimum block spacing: 128 cycles; back-to-back full-rate streaming with `ready_in`=1 sustains 100% throughput without overrun.
- `overrun` and `abort` are registered pulses asserted for exactly the cycle after the triggering edge.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `SBL_TIMEOUT_EN` defined: an 8-bit gap counter increments each cycle in LOAD with `data_valid_in`=0 and clears on any valid bit or in IDLE. On reaching `TIMEOUT_CYC`, `sr` and `bit_cnt` clear, collector -> IDLE, `abort` pulses; output register unaffected.
- Not defined: no gap counter; a partial block waits indefinitely; `abort` tied 0.

## Test plan
- Reset, then 128 consecutive valid bits of 128'h000102030405060708090A0B0C0D0E0F MSB-first, `ready_in`=1 -> `valid_out`=1 for one cycle after bit 128 with that exact `block_out`; `bit_cnt` returns 0.
- Same block with random 1-3 cycle `data_valid_in` gaps (below timeout) -> identical `block_out`; `bit_cnt` pauses during gaps.
- `ready_in`=0 after first block, stream second block 128'hFFFF...FFFF -> first block held unchanged, `overrun` pulses once at second completion; raising `ready_in` -> `valid_out` drops next cycle.
- Completion of block 2 on the same edge `ready_in`=1 consumes block 1 -> `valid_out` stays 1, `block_out` = block 2, no `overrun`.
- `SBL_TIMEOUT_EN`, `TIMEOUT_CYC`=16: send 40 bits, idle 16 cycles -> `abort` pulse, `bit_cnt`=0; then full block -> correct output. Without macro: same stimulus -> no abort, block completes after 88 more bits with the first 40 bits included.
- Assert `reset` after 60 bits with a block held -> all outputs 0 immediately; next 128 bits produce a clean block.

Source files
------------

// File: rtl/serial_block_loader_if.sv
// serial_block_loader_if: serial input stream and block output handshake of serial_block_loader
interface serial_block_loader_if;
  logic         data_valid_in;
  logic         data_in;
  logic         ready_in;
  logic [127:0] block_out;
  logic         valid_out;
  logic [6:0]   bit_cnt;
  logic         overrun;
  logic         abort;
  modport master (output data_valid_in, data_in, ready_in,
                  input  block_out, valid_out, bit_cnt, overrun, abort);
  modport slave  (input  data_valid_in, data_in, ready_in,
                  output block_out, valid_out, bit_cnt, overrun, abort);
endinterface

// File: rtl/serial_block_loader.sv
// serial_block_loader: shifts a serial MSB-first stream into 128-bit blocks and holds one for a valid/ready consumer.
// SBL_TIMEOUT_EN enables the idle-gap timeout (TIMEOUT_CYC) that discards a stalled partial block.
module serial_block_loader
`ifdef SBL_TIMEOUT_EN
  #(parameter int TIMEOUT_CYC = 16)
`endif
  (
  input logic clk,
  input logic reset,
  serial_block_loader_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0, FULL = 1'b1;
  logic [127:0] sr, blk;
  logic [6:0]   cnt;
  logic [0:0]   state;
  logic         ovr, complete, load, tmo;
  assign complete = bus.data_valid_in && cnt == 7'd127;
  // A completing block replaces the held one only if the held one leaves on the same edge.
  assign load = complete && (state == EMPTY || bus.ready_in);
`ifdef SBL_TIMEOUT_EN
  logic [7:0] gap;
  logic       abt;
  assign tmo = cnt != 7'd0 && !bus.data_valid_in && gap + 8'd1 == 8'(TIMEOUT_CYC);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap <= '0;
      abt <= 1'b0;
    end else begin
      abt <= tmo;
      gap <= (bus.data_valid_in || cnt == 7'd0 || tmo) ? 8'd0 : gap + 8'd1;
    end
  end
  assign bus.abort = abt;
`else
  assign tmo = 1'b0;
  assign bus.abort = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr    <= '0;
      cnt   <= '0;
      blk   <= '0;
      state <= EMPTY;
      ovr   <= 1'b0;
    end else begin
      ovr <= complete && state == FULL && !bus.ready_in;
      if (tmo) begin
        sr  <= '0;
        cnt <= '0;
      end else if (bus.data_valid_in) begin
        sr  <= {sr[126:0], bus.data_in};
        cnt <= cnt + 7'd1;
      end
      if (load) begin
        blk   <= {sr[126:0], bus.data_in};
        state <= FULL;
      end else if (state == FULL && bus.ready_in) begin
        state <= EMPTY;
      end
    end
  end
  assign bus.block_out = blk;
  assign bus.valid_out = state == FULL;
  assign bus.bit_cnt   = cnt;
  assign bus.overrun   = ovr;
endmodule

// File: tb/tb_serial_block_loader.sv
// tb_serial_block_loader: scoreboard bench for serial_block_loader; expected blocks queued at stimulus, popped at completion.
module tb_serial_block_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  serial_block_loader_if bus();
  serial_block_loader dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cnt_m = 0, ov_cnt = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_blk;
  localparam logic [127:0] B1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] B2 = {128{1'b1}};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bits(input logic [127:0] blk, input int hi, input int lo, input int max_gap, input logic rdy_last);
    for (int i = hi; i >= lo; i--) begin
      int g;
      g = max_gap > 0 ? int'($urandom_range(max_gap, 1)) : 0;
      for (int k = 0; k < g; k++) begin
        bus.data_valid_in = 1'b0;
        tick();
        checks++;
        if (bus.bit_cnt !== 7'(cnt_m)) begin
          errors++;
          $display("FAIL gap_bit_cnt: got %0d expected %0d", bus.bit_cnt, cnt_m);
        end
      end
      bus.data_valid_in = 1'b1;
      bus.data_in = blk[i];
      if (i == 0) bus.ready_in = rdy_last;
      tick();
      cnt_m = (cnt_m + 1) % 128;
      if (bus.overrun) ov_cnt++;
    end
    bus.data_valid_in = 1'b0;
  endtask
  task automatic check_block(input string name);
    exp_blk = exp_q.pop_front();
    checks += 3;
    if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", name, bus.valid_out); end
    if (bus.block_out !== exp_blk) begin errors++; $display("FAIL %s_block: got %h expected %h", name, bus.block_out, exp_blk); end
    if (bus.bit_cnt !== 7'd0) begin errors++; $display("FAIL %s_bit_cnt: got %0d expected 0", name, bus.bit_cnt); end
  endtask
  task automatic test_reset();
    bus.data_valid_in = 1'b0;
    bus.data_in = 1'b0;
    bus.ready_in = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checks += 5;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out); end
    if (bus.block_out !== 128'd0) begin errors++; $display("FAIL reset_block: got %h expected 0", bus.block_out); end
    if (bus.bit_cnt !== 7'd0) begin errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", bus.bit_cnt); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    if (bus.abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", bus.abort); end
    reset = 1'b0;
    cnt_m = 0;
  endtask
  task automatic test_basic();
    bus.ready_in = 1'b1;
    exp_q.push_back(B1);
    send_bits(B1, 127, 0, 0, 1'b1);
    check_block("basic");
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL basic_consumed: got %b expected 0", bus.valid_out); end
  endtask
  task automatic test_gaps();
    bus.ready_in = 1'b1;
    exp_q.push_back(B1);
    send_bits(B1, 127, 0, 3, 1'b1);
    check_block("gaps");
    tick();
  endtask
  task automatic test_overrun();
    bus.ready_in = 1'b0;
    exp_q.push_back(B1);
    send_bits(B1, 127, 0, 0, 1'b0);
    check_block("ovr_first");
    exp_q.push_back(B1);
    ov_cnt = 0;
    send_bits(B2, 127, 0, 0, 1'b0);
    check_block("ovr_held");
    checks += 2;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b expected 1", bus.overrun); end
    if (ov_cnt !== 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", ov_cnt); end
    tick();
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_end: got %b expected 0", bus.overrun); end
    bus.ready_in = 1'b1;
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL ovr_release: got %b expected 0", bus.valid_out); end
  endtask
  task automatic test_back_to_back();
    bus.ready_in = 1'b0;
    exp_q.push_back(B1);
    send_bits(B1, 127, 0, 0, 1'b0);
    check_block("b2b_first");
    exp_q.push_back(B2);
    ov_cnt = 0;
    send_bits(B2, 127, 0, 0, 1'b1);
    check_block("b2b_second");
    checks++;
    if (ov_cnt !== 0) begin errors++; $display("FAIL b2b_overrun: got %0d expected 0", ov_cnt); end
    tick();
  endtask
  task automatic test_timeout();
    logic [127:0] c;
    int ab;
    c = {$urandom, $urandom, $urandom, $urandom};
    bus.ready_in = 1'b1;
    ab = 0;
    send_bits(c, 127, 88, 0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (bus.abort) ab++;
    end
`ifdef SBL_TIMEOUT_EN
    checks += 3;
    if (ab !== 1) begin errors++; $display("FAIL timeout_abort: got %0d expected 1", ab); end
    if (bus.bit_cnt !== 7'd0) begin errors++; $display("FAIL timeout_bit_cnt: got %0d expected 0", bus.bit_cnt); end
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b expected 0", bus.valid_out); end
    cnt_m = 0;
    c = ~c;
    exp_q.push_back(c);
    send_bits(c, 127, 0, 0, 1'b1);
`else
    checks += 2;
    if (ab !== 0) begin errors++; $display("FAIL timeout_abort: got %0d expected 0", ab); end
    if (bus.bit_cnt !== 7'd40) begin errors++; $display("FAIL timeout_bit_cnt: got %0d expected 40", bus.bit_cnt); end
    exp_q.push_back(c);
    send_bits(c, 87, 0, 0, 1'b1);
`endif
    check_block("timeout");
    tick();
  endtask
  task automatic test_reset_mid();
    bus.ready_in = 1'b0;
    exp_q.push_back(B2);
    send_bits(B2, 127, 0, 0, 1'b0);
    check_block("rst_held");
    send_bits(B1, 127, 68, 0, 1'b0);
    reset = 1'b1;
    #1;
    checks += 3;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus.valid_out); end
    if (bus.block_out !== 128'd0) begin errors++; $display("FAIL rst_mid_block: got %h expected 0", bus.block_out); end
    if (bus.bit_cnt !== 7'd0) begin errors++; $display("FAIL rst_mid_bit_cnt: got %0d expected 0", bus.bit_cnt); end
    tick();
    reset = 1'b0;
    cnt_m = 0;
    bus.ready_in = 1'b1;
    exp_q.push_back(B1);
    send_bits(B1, 127, 0, 0, 1'b1);
    check_block("rst_clean");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
